// File: rtl/mod_counter.sv
// Up/down modulo counter with programmable modulus, wrap or saturate mode,
// count-enable prescaler, registered terminal-count pulse and sticky
// boundary (overflow) flag.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] v,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  // Prescaler width; a PRESCALE of 1 still gets a single (always-zero) bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Top of the count range, held one bit wider than the counter so that
  // MODULUS == 2**WIDTH compares correctly without any truncation.
  localparam logic [WIDTH:0]  CNT_MAX  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             tc_q,    tc_d;
  logic             ovf_q,   ovf_d;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_val;

  // Boundary detection and load clamping, compared at WIDTH+1 bits.
  always_comb begin
    at_max   = ({1'b0, count_q} == CNT_MAX);
    at_min   = (count_q == '0);
    load_val = ({1'b0, v} > CNT_MAX) ? CNT_MAX[WIDTH-1:0] : v;
  end

  // Next-state logic: reset > load > prescaled step.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is
    // inferred on paths that do not update it.
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (rst) begin
      count_d = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else if (ld) begin
      count_d = load_val;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (up) begin
          if (at_max) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            if (!sat) count_d = '0;
          end else begin
            // Only reached below the top of range, so never relies on
            // natural 2**WIDTH rollover.
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (at_min) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            if (!sat) count_d = CNT_MAX[WIDTH-1:0];
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // State registers; reset is handled synchronously in the next-state logic.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from the
    // pre-edge values, independent of statement order.
    count_q <= count_d;
    pre_q   <= pre_d;
    tc_q    <= tc_d;
    ovf_q   <= ovf_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
